// File: rtl/fifo_burst_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_burst_ctrl
//
// Sequencer for a counter-fed FIFO datapath. It fills the FIFO with
// incrementing counter words up to FILL_LEVEL, then drains it in read bursts
// of BURST_LEN words. Each read word returns RD_LAT cycles after RE. It is
// registered onto dout with a one-cycle dout_valid strobe, and each word is
// checked to be the previous word + 1. FIFO overflow, FIFO underflow and
// sequence breaks park the controller in ERR with a sticky error code until
// clr is asserted.
//
// Ports
//   REF_CLK_0   in   1   clock, rising edge
//   rstn        in   1   asynchronous active-low reset (shared with the FIFO)
//   en          in   1   start pulse, honoured only in IDLE
//   clr         in   1   abort a run / clear a latched error
//   AFULL       in   1   FIFO almost-full, stalls writes
//   AEMPTY      in   1   FIFO almost-empty, stalls reads
//   OVERFLOW    in   1   FIFO overflow flag
//   UNDERFLOW   in   1   FIFO underflow flag
//   Q           in   DW  FIFO read data
//   WE          out  1   FIFO write enable (combinational)
//   RE          out  1   FIFO read enable (combinational)
//   cnt_en      out  1   data-counter advance, identical to WE
//   dout        out  DW  forwarded read word, held between strobes
//   dout_valid  out  1   one-cycle qualifier per forwarded word
//   busy        out  1   high in every state except IDLE
//   err         out  1   sticky error flag
//   err_code    out  2   01 overflow, 10 underflow, 11 sequence, 00 none
//   burst_cnt   out  8   bursts completed in this run, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fifo_burst_ctrl #(
    parameter int DW         = 20,
    parameter int DEPTH      = 64,
    parameter int LVLW       = 7,
    parameter int FILL_LEVEL = 48,
    parameter int BURST_LEN  = 32,
    parameter int RD_LAT     = 1,
    parameter int NUM_BURSTS = 0
) (
    input  logic          REF_CLK_0,
    input  logic          rstn,
    input  logic          en,
    input  logic          clr,
    input  logic          AFULL,
    input  logic          AEMPTY,
    input  logic          OVERFLOW,
    input  logic          UNDERFLOW,
    input  logic [DW-1:0] Q,
    output logic          WE,
    output logic          RE,
    output logic          cnt_en,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    burst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [LVLW-1:0] FILL_LVL_C   = LVLW'(FILL_LEVEL);
    localparam logic [LVLW-1:0] BURST_C      = LVLW'(BURST_LEN);
    localparam logic [LVLW-1:0] DEPTH_C      = LVLW'(DEPTH);
    localparam logic [LVLW-1:0] LVL_ZERO_C   = LVLW'(0);
    localparam logic [LVLW-1:0] LVL_ONE_C    = LVLW'(1);
    localparam logic [1:0]      FLUSH_LAST_C = 2'(RD_LAT - 1);
    localparam logic [7:0]      NUM_BURSTS_C = 8'(NUM_BURSTS);
    localparam logic [RD_LAT-1:0] PIPE_ZERO_C = RD_LAT'(0);
    localparam logic [DW-1:0]   DW_ZERO_C    = DW'(0);
    localparam logic [DW-1:0]   DW_ONE_C     = DW'(1);

    // Error code with fixed priority: overflow, then underflow, then sequence.
    function automatic logic [1:0] f_err_code(input logic ovf,
                                              input logic unf,
                                              input logic seq);
        logic [1:0] code;
        if (ovf) begin
            code = 2'b01;
        end else if (unf) begin
            code = 2'b10;
        end else if (seq) begin
            code = 2'b11;
        end else begin
            code = 2'b00;
        end
        return code;
    endfunction

    state_t            r_state;
    state_t            w_next;
    logic [LVLW-1:0]   r_level;
    logic [LVLW-1:0]   r_rd_issued;
    logic [1:0]        r_flush_cnt;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic [DW-1:0]     r_prev;
    logic              r_seq_armed;

    logic              w_we;
    logic              w_re;
    logic              w_active;
    logic              w_seq_err;
    logic              w_err_hit;
    logic              w_burst_done;
    logic              w_drop_pipe;
    logic              w_q_valid;
    logic [7:0]        w_burst_next;

    assign w_active     = (r_state == S_FILL) || (r_state == S_DRAIN) || (r_state == S_FLUSH);
    // The first word after a start is the reference, so it is never flagged.
    assign w_seq_err    = dout_valid && r_seq_armed && (dout != (r_prev + DW_ONE_C));
    assign w_err_hit    = w_active && (OVERFLOW || UNDERFLOW || w_seq_err);
    assign w_burst_next = burst_cnt + 8'd1;
    // Words still in flight are discarded whenever the run stops abruptly.
    assign w_drop_pipe  = (w_next == S_ERR) || (w_next == S_IDLE);
    assign w_q_valid    = r_rd_pipe[RD_LAT-1];

    assign WE     = w_we;
    assign cnt_en = w_we;
    assign RE     = w_re;
    assign busy   = (r_state != S_IDLE);

    // Next-state and FIFO strobe decode.
    always_comb begin
        w_next       = r_state;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_burst_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next = S_FILL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FILL: begin
                // WE depends only on state, level and AFULL; the DEPTH bound is a backstop.
                w_we = (r_level < FILL_LVL_C) && (r_level < DEPTH_C) && !AFULL;
                if (w_err_hit) begin
                    w_next = S_ERR;
                end else if (clr) begin
                    w_next = S_IDLE;
                end else if (r_level == FILL_LVL_C) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_DRAIN: begin
                w_re = (r_rd_issued < BURST_C) && (r_level != LVL_ZERO_C) && !AEMPTY;
                if (w_err_hit) begin
                    w_next = S_ERR;
                end else if (clr) begin
                    w_next = S_IDLE;
                end else if ((r_rd_issued == BURST_C) || (r_level == LVL_ZERO_C)) begin
                    w_next = S_FLUSH;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (w_err_hit) begin
                    w_next = S_ERR;
                end else if (clr) begin
                    w_next = S_IDLE;
                end else if (r_flush_cnt == FLUSH_LAST_C) begin
                    w_burst_done = 1'b1;
                    if ((NUM_BURSTS_C != 8'd0) && (w_burst_next == NUM_BURSTS_C)) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_FILL;
                    end
                end else begin
                    w_next = S_FLUSH;
                end
            end
            S_ERR: begin
                if (clr) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ERR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FIFO occupancy mirror; kept across clr because the FIFO keeps its words.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_level <= LVL_ZERO_C;
        end else if (w_we) begin
            r_level <= r_level + LVL_ONE_C;
        end else if (w_re) begin
            r_level <= r_level - LVL_ONE_C;
        end else begin
            r_level <= r_level;
        end
    end

    // Reads issued in the current drain burst.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_rd_issued <= LVL_ZERO_C;
        end else if (r_state != S_DRAIN) begin
            r_rd_issued <= LVL_ZERO_C;
        end else if (w_re) begin
            r_rd_issued <= r_rd_issued + LVL_ONE_C;
        end else begin
            r_rd_issued <= r_rd_issued;
        end
    end

    // Cycles spent waiting in FLUSH for the last read word.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_flush_cnt <= 2'd0;
        end else if (r_state != S_FLUSH) begin
            r_flush_cnt <= 2'd0;
        end else begin
            r_flush_cnt <= r_flush_cnt + 2'd1;
        end
    end

    // Completed-burst counter, restarted by each new run.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            burst_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && en) begin
            burst_cnt <= 8'd0;
        end else if (w_burst_done) begin
            burst_cnt <= w_burst_next;
        end else begin
            burst_cnt <= burst_cnt;
        end
    end

    // Read-latency pipeline: bit k set means a read issued k+1 cycles ago.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_rd_pipe <= PIPE_ZERO_C;
        end else if (w_drop_pipe) begin
            r_rd_pipe <= PIPE_ZERO_C;
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1'b1) | RD_LAT'(w_re);
        end
    end

    // Capture returning FIFO data onto dout; dout holds between strobes.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            dout       <= DW_ZERO_C;
            dout_valid <= 1'b0;
        end else if (w_q_valid && !w_drop_pipe) begin
            dout       <= Q;
            dout_valid <= 1'b1;
        end else begin
            dout       <= dout;
            dout_valid <= 1'b0;
        end
    end

    // Sequence reference: last forwarded word and whether one exists yet.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            r_prev      <= DW_ZERO_C;
            r_seq_armed <= 1'b0;
        end else if ((r_state == S_IDLE) && en) begin
            r_prev      <= r_prev;
            r_seq_armed <= 1'b0;
        end else if (dout_valid) begin
            r_prev      <= dout;
            r_seq_armed <= 1'b1;
        end else begin
            r_prev      <= r_prev;
            r_seq_armed <= r_seq_armed;
        end
    end

    // Sticky error flag and code; only clr in ERR releases them.
    always_ff @(posedge REF_CLK_0 or negedge rstn) begin
        if (!rstn) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end else if (w_err_hit) begin
            err      <= 1'b1;
            err_code <= f_err_code(OVERFLOW, UNDERFLOW, w_seq_err);
        end else if ((r_state == S_ERR) && clr) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            err      <= err;
            err_code <= err_code;
        end
    end

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_ctrl
//
// Self-checking bench for fifo_burst_ctrl. A behavioural FIFO fed by a write
// counter supplies Q one cycle after RE. Every RE pushes the expected word
// (the read index, which is the counter value written in that slot) and its
// due cycle onto a scoreboard. Every dout_valid pops the scoreboard and
// compares both the word and the cycle it arrived on.
// -----------------------------------------------------------------------------
module tb_fifo_burst_ctrl;

    localparam int DW     = 20;
    localparam int RD_LAT = 1;
    localparam int NB     = 2;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          en     = 1'b0;
    logic          clr    = 1'b0;
    logic          afull  = 1'b0;
    logic          aempty = 1'b0;
    logic          ovf    = 1'b0;
    logic          unf    = 1'b0;
    logic [DW-1:0] q      = '0;

    logic          we, re, cnt_en, dout_valid, busy, err;
    logic [DW-1:0] dout;
    logic [1:0]    err_code;
    logic [7:0]    burst_cnt;

    fifo_burst_ctrl #(
        .DW(DW), .DEPTH(64), .LVLW(7), .FILL_LEVEL(48), .BURST_LEN(32),
        .RD_LAT(RD_LAT), .NUM_BURSTS(NB)
    ) u_dut (
        .REF_CLK_0(clk), .rstn(rstn), .en(en), .clr(clr),
        .AFULL(afull), .AEMPTY(aempty), .OVERFLOW(ovf), .UNDERFLOW(unf),
        .Q(q), .WE(we), .RE(re), .cnt_en(cnt_en), .dout(dout),
        .dout_valid(dout_valid), .busy(busy), .err(err),
        .err_code(err_code), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
        bit            bad;
    } exp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    exp_t          sb[$];
    logic [DW-1:0] fifo_m[$];
    int            wcnt = 0, pop_idx = 0, rd_idx = 0, skip_idx = -1;
    int            wr_tot = 0, rd_tot = 0;
    int            we_run = 0, last_run = 0;
    int            err_cyc = -100, bad_cyc = -100;
    logic          err_d = 1'b0;
    logic [DW-1:0] last_dout = '0;
    logic          we_s = 1'b0, re_s = 1'b0;
    int            w0, r0, r1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // FIFO model: applies the strobes sampled at the previous falling edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rstn) begin
            fifo_m.delete();
            wcnt    = 0;
            pop_idx = 0;
            q       = '0;
        end else begin
            if (we_s) begin
                fifo_m.push_back(DW'(wcnt));
                wcnt++;
            end
            if (re_s) begin
                if (fifo_m.size() > 0) q = fifo_m.pop_front();
                else q = '0;
                if (pop_idx == skip_idx) q = q + 1'b1;
                pop_idx++;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            we_s = 1'b0;
            re_s = 1'b0;
            sb.delete();
            rd_idx = 0;
            we_run = 0;
            err_d  = 1'b0;
        end else begin
            we_s = we;
            re_s = re;
            chk("we_re_excl", {31'd0, we & re}, 32'd0);
            chk("cnt_en_eq_we", {31'd0, cnt_en}, {31'd0, we});
            if (we) begin
                wr_tot++;
                we_run++;
            end else begin
                if (we_run > 0) last_run = we_run;
                we_run = 0;
            end
            if (re) begin
                sb.push_back('{d: (rd_idx == skip_idx) ? DW'(rd_idx + 1) : DW'(rd_idx),
                               c: cyc + RD_LAT + 1, bad: (rd_idx == skip_idx)});
                rd_idx++;
                rd_tot++;
            end
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dout", {12'd0, dout}, {12'd0, e.d});
                    chk("dout_cycle", cyc, e.c);
                    last_dout = dout;
                    if (e.bad) bad_cyc = cyc;
                end
            end
            if ((sb.size() > 0) && (sb[0].c < cyc)) begin
                chk("sb_missing_valid", cyc, sb[0].c);
                void'(sb.pop_front());
            end
            if (err || !busy) sb.delete();
            if (err && !err_d) err_cyc = cyc;
            err_d = err;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_re"}, {31'd0, re}, 32'd0);
        chk({tag, "_cnt_en"}, {31'd0, cnt_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_burst_cnt"}, {24'd0, burst_cnt}, 32'd0);
        chk({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_dout"}, {12'd0, dout}, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b0; clr = 1'b0; afull = 1'b0;
        aempty = 1'b0; ovf = 1'b0; unf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rstn = 1'b1;
    endtask

    task automatic pulse_en();
        @(posedge clk); #1; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
    endtask

    task automatic wait_re(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (re !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, re}, 32'd1);
    endtask

    task automatic wait_burst(input string tag, input int n);
        int i;
        i = 0;
        while (burst_cnt != 8'(n) && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        chk(tag, {24'd0, burst_cnt}, n);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_wr(input string tag, input int base, input int n);
        int i;
        i = 0;
        while ((wr_tot - base) < n && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        chk(tag, wr_tot - base, n);
    endtask

    task automatic wait_err(input string tag);
        int i;
        i = 0;
        while (!err && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        chk(tag, {31'd0, err}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Plain run of two bursts: fill 48, drain 0..31, refill 32, drain 32..63.
        do_reset();
        w0 = wr_tot; r0 = rd_tot;
        pulse_en();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_re("t1_first_re");
        chk("t1_fill_writes", wr_tot - w0, 48);
        chk("t1_we_run", last_run, 48);
        wait_burst("t1_burst1", 1);
        chk("t1_reads", rd_tot - r0, 32);
        chk("t1_last_dout", {12'd0, last_dout}, 31);
        wait_re("t1_refill_re");
        chk("t1_refill_writes", wr_tot - w0, 80);
        chk("t1_refill_run", last_run, 32);
        wait_idle("t2_idle");
        chk("t2_burst_cnt", {24'd0, burst_cnt}, 2);
        chk("t2_last_dout", {12'd0, last_dout}, 63);
        chk("t2_reads", rd_tot - r0, 64);
        chk("t2_err", {31'd0, err}, 32'd0);

        // AFULL stall at level 20 for 5 cycles.
        do_reset();
        w0 = wr_tot;
        pulse_en();
        wait_wr("t3_reach20", w0, 20);
        afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_we", {31'd0, we}, 32'd0);
            chk("t3_stall_re", {31'd0, re}, 32'd0);
            chk("t3_stall_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        afull = 1'b0;
        chk("t3_stall_writes", wr_tot - w0, 20);
        @(negedge clk);
        chk("t3_resume_we", {31'd0, we}, 32'd1);
        wait_re("t3_first_re");
        chk("t3_fill_writes", wr_tot - w0, 48);
        chk("t3_we_run", last_run, 28);
        wait_idle("t3_idle");

        // OVERFLOW during DRAIN, then clr.
        pulse_en();
        wait_re("t4_re");
        @(posedge clk); #1; ovf = 1'b1;
        @(posedge clk); #1; ovf = 1'b0;
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_err_code", {30'd0, err_code}, 32'd1);
        chk("t4_we", {31'd0, we}, 32'd0);
        chk("t4_re", {31'd0, re}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        chk("t4_valid_suppressed", {31'd0, dout_valid}, 32'd0);
        r1 = rd_tot;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_reads", rd_tot - r1, 0);
        chk("t4_err_held", {31'd0, err}, 32'd1);
        pulse_clr();
        chk("t4_clr_err", {31'd0, err}, 32'd0);
        chk("t4_clr_code", {30'd0, err_code}, 32'd0);
        chk("t4_clr_busy", {31'd0, busy}, 32'd0);

        // Sequence break: the 7th word of the run is returned one too high.
        skip_idx = rd_idx + 6;
        pulse_en();
        wait_err("t5_err");
        @(negedge clk); #1;
        chk("t5_err_code", {30'd0, err_code}, 32'd3);
        chk("t5_err_latency", err_cyc, bad_cyc + 1);
        r1 = rd_tot;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_reads", rd_tot - r1, 0);
        chk("t5_we", {31'd0, we}, 32'd0);
        pulse_clr();
        skip_idx = -1;
        chk("t5_clr_err", {31'd0, err}, 32'd0);

        // en during FILL is ignored; async reset in the second DRAIN.
        do_reset();
        w0 = wr_tot;
        pulse_en();
        wait_wr("t6_reach10", w0, 10);
        pulse_en();
        wait_re("t6_first_re");
        chk("t6_fill_writes", wr_tot - w0, 48);
        wait_burst("t6_burst1", 1);
        wait_re("t6_drain2");
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check_zero("t6_async");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_after_rst_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_ctrl.md
Name: fifo_burst_ctrl

Overview:
Sequencer for the counter-fed FIFO datapath. It fills the FIFO with incrementing counter words up to a threshold, then drains it in fixed-length read bursts. Read data is forwarded with a valid strobe and checked for sequence continuity. FIFO OVERFLOW, UNDERFLOW and sequence breaks are latched as errors.

Parameters:
DW, 20, FIFO data width (Q/dout)
DEPTH, 64, FIFO depth in words
LVLW, 7, width of internal occupancy counter (must hold 0..DEPTH)
FILL_LEVEL, 48, occupancy at which FILL ends (1..DEPTH)
BURST_LEN, 32, reads per drain burst (1..FILL_LEVEL)
RD_LAT, 1, FIFO read latency in cycles, RE to Q valid (1..3)
NUM_BURSTS, 0, bursts per run; 0 = run until clr

Ports:
REF_CLK_0  in  1  sole clock, rising edge
rstn  in  1  asynchronous, active-low reset; shared with FIFO
en  in  1  start pulse, sampled only in IDLE
clr  in  1  abort run / clear error
AFULL  in  1  FIFO almost-full
AEMPTY  in  1  FIFO almost-empty
OVERFLOW  in  1  FIFO overflow flag
UNDERFLOW  in  1  FIFO underflow flag
Q  in  DW  FIFO read data
WE  out  1  FIFO write enable
RE  out  1  FIFO read enable
cnt_en  out  1  data-counter advance; identical to WE
dout  out  DW  forwarded read word
dout_valid  out  1  dout qualifier, 1-cycle strobe per word
busy  out  1  high in any state except IDLE
err  out  1  sticky error
err_code  out  2  01 overflow, 10 underflow, 11 sequence, 00 none
burst_cnt  out  8  completed bursts this run, wraps 255->0

Behaviour:
- Reset (rstn=0, async): state IDLE; level=0; all outputs 0; latency pipeline cleared.
- States: IDLE, FILL, DRAIN, FLUSH, ERR.
- IDLE: en=1 -> FILL; burst_cnt cleared; sequence checker re-armed (first word not checked).
- FILL: WE=cnt_en=1 in every cycle with level<FILL_LEVEL and AFULL=0. WE is combinational from state/level/AFULL only. level+1 per WE. When level==FILL_LEVEL, go to DRAIN; WE is 0 in that cycle. AFULL=1 stalls WE without a state change.
- DRAIN: RE=1 in every cycle with rd_issued<BURST_LEN, level>0 and AEMPTY=0. level-1 per RE. Go to FLUSH when rd_issued==BURST_LEN or level==0.
- FLUSH: waits RD_LAT cycles so the last word returns. Then burst_cnt+1. If NUM_BURSTS!=0 and new burst_cnt==NUM_BURSTS, go to IDLE; else go to FILL.
- WE and RE are never high in the same cycle.
- Data path: RE at cycle t, Q sampled at t+RD_LAT, registered to dout with dout_valid=1 at t+RD_LAT+1. dout holds its value between strobes.
- Sequence check: each valid dout must equal the previous valid dout+1 mod 2^DW. A mismatch raises an error with code 11.
- Errors: OVERFLOW or UNDERFLOW high in any non-IDLE state, or a sequence mismatch -> ERR on the next edge. err=1. Code priority: overflow > underflow > sequence.
- ERR: WE=RE=cnt_en=0; pending dout_valid suppressed; busy=1. Only clr exits, to IDLE, clearing err/err_code. level is kept.
- clr in FILL/DRAIN/FLUSH: abort to IDLE next edge; latency pipeline discarded; burst_cnt kept.
- en outside IDLE: ignored.
- FIFO/controller occupancy coherence relies on a shared reset. level never exceeds DEPTH.

Test Plan:
1. Reset, en pulse, defaults, Q mirrors written data -> 48 consecutive WE cycles, then 32 RE cycles. dout=0..31 with dout_valid 2 cycles after each RE. burst_cnt=1. Refill issues 32 WE (level 16->48).
2. NUM_BURSTS=2 -> after second FLUSH returns to IDLE, busy=0, burst_cnt=2, dout last=63 (first burst 0..31, refill to 48, second burst 32..63).
3. Hold AFULL=1 for 5 cycles at level 20 during FILL -> WE=0 those cycles, state stays FILL, resumes at level 20, still exactly 48 total writes.
4. Pulse OVERFLOW during DRAIN -> next cycle ERR, WE=RE=0, err=1, err_code=01. clr -> IDLE, err=0, err_code=00.
5. Force Q to skip a value (…,5,7) -> err_code=11 one cycle after the bad dout, no further RE.
6. Assert rstn=0 mid-DRAIN -> outputs 0 immediately (async). en during FILL -> no effect on write count.
